// File: rtl/bitplane_stream_packer.sv
// Collects LANES operand words into a ping-pong buffer and emits NSLICE bit-slice words, lane 0 at the LSBs.
// A group closed at edge T is valid from the next cycle; in_ready drops when both banks are full, output holds while out_ready is low.
module bitplane_stream_packer #(
  parameter int LANES   = 16,
  parameter int WORD_W  = 32,
  parameter int SLICE_W = 2,
  localparam int NSLICE = WORD_W / SLICE_W,
  localparam int PACK_W = LANES * SLICE_W,
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int SW     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PACK_W-1:0] out_data,
  output logic [SW-1:0]     out_idx,
  output logic              out_last
);

  localparam int NW = LW + 1;

  typedef logic [NSLICE-1:0][SLICE_W-1:0] word_t;

  word_t                        mem [2][LANES];
  logic [1:0]                   full;
  logic [NW-1:0]                nlanes [2];
  logic                         wr_bank;
  logic                         rd_bank;
  logic [LW-1:0]                lane_cnt;
  logic [SW-1:0]                slice_cnt;
  logic                         in_fire;
  logic                         out_fire;
  logic                         grp_close;
  logic [LANES-1:0][SLICE_W-1:0] pack;

  assign in_ready  = reset & ~full[wr_bank];
  assign in_fire   = in_valid & in_ready;
  // A flush only closes a group that holds at least one word, counting the one arriving now.
  assign grp_close = (in_fire && (lane_cnt == LW'(LANES - 1))) ||
                     (flush && in_ready && ((lane_cnt != '0) || in_fire));

  assign out_valid = full[rd_bank];
  assign out_fire  = out_valid & out_ready;
  assign out_idx   = slice_cnt;
  assign out_last  = out_valid && (slice_cnt == SW'(NSLICE - 1));

  always_comb begin
    pack = '0;
    if (out_valid) begin
      for (int k = 0; k < LANES; k++) begin
        if (NW'(k) < nlanes[rd_bank]) pack[k] = mem[rd_bank][k][slice_cnt];
      end
    end
  end

  assign out_data = pack;

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_bank][lane_cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full      <= '0;
      nlanes[0] <= '0;
      nlanes[1] <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      lane_cnt  <= '0;
      slice_cnt <= '0;
    end else begin
      if (in_fire) lane_cnt <= lane_cnt + LW'(1);
      if (grp_close) begin
        full[wr_bank]   <= 1'b1;
        nlanes[wr_bank] <= {1'b0, lane_cnt} + NW'(in_fire);
        wr_bank         <= ~wr_bank;
        lane_cnt        <= '0;
      end
      // Closing and freeing in one cycle always touch different banks: a closing bank is empty, a draining one is full.
      if (out_fire) begin
        if (out_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          slice_cnt     <= '0;
        end else begin
          slice_cnt <= slice_cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bitplane_stream_packer.sv
// Directed bench for bitplane_stream_packer at default parameters (16 lanes, 32-bit words, 2-bit slices).
module tb_bitplane_stream_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;

  always #5 clk = ~clk;

  bitplane_stream_packer #(.LANES(16), .WORD_W(32), .SLICE_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last)
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        fl;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [3:0]  e_idx;
    logic        e_last;
  } vec_t;

  localparam int NVEC = 58;
  vec_t        tbl [NVEC];
  logic [31:0] src [64];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference transpose: beat s of a group of n words starting at src[base].
  function automatic logic [31:0] tp(input int base, input int n, input int s);
    logic [31:0] r;
    logic [31:0] w;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < n) begin
        w = src[base + k];
        r[2*k +: 2] = w[2*s +: 2];
      end
    end
    return r;
  endfunction

  task automatic set_row(input int i, input logic iv, input logic [31:0] id, input logic fl,
                         input logic e_irdy, input logic e_ov, input logic [31:0] e_od,
                         input int e_idx, input logic e_last);
    tbl[i].iv     = iv;
    tbl[i].id     = id;
    tbl[i].fl     = fl;
    tbl[i].e_irdy = e_irdy;
    tbl[i].e_ov   = e_ov;
    tbl[i].e_od   = e_od;
    tbl[i].e_idx  = 4'(e_idx);
    tbl[i].e_last = e_last;
  endtask

  task automatic push_word(input logic [31:0] w, input logic f);
    int t;
    in_valid = 1'b1;
    in_data  = w;
    flush    = f;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      t++;
    end
    chk("push_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain(input int base, input int n, input string nm);
    int t;
    for (int s = 0; s < 16; s++) begin
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 40) begin
        @(posedge clk); #1;
        @(negedge clk);
        t++;
      end
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_idx"}, out_idx, s);
      chk({nm, "_data"}, out_data, tp(base, n, s));
      chk({nm, "_last"}, out_last, (s == 15));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wi, beats, first, lastc, drops, t;

    // Identity diagonal, then a 5-word flush group and an empty flush.
    for (int k = 0; k < 16; k++) set_row(k, 1, 32'h3 << (2*k), 0, 1, 0, 0, 0, 0);
    for (int s = 0; s < 16; s++) set_row(16 + s, 0, 0, 0, 1, 1, 32'h3 << (2*s), s, s == 15);
    set_row(32, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) set_row(33 + k, 1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
    set_row(38, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int s = 0; s < 16; s++) set_row(39 + s, 0, 0, 0, 1, 1, 32'h0000_03FF, s, s == 15);
    set_row(55, 0, 0, 1, 1, 0, 0, 0, 0);
    set_row(56, 0, 0, 0, 1, 0, 0, 0, 0);
    set_row(57, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset with a pending input word.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
    end
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      in_valid = tbl[i].iv;
      in_data  = tbl[i].id;
      flush    = tbl[i].fl;
      @(negedge clk);
      chk("tbl_in_ready", in_ready, tbl[i].e_irdy);
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      chk("tbl_out_last", out_last, tbl[i].e_last);
      if (tbl[i].e_ov) begin
        chk("tbl_out_data", out_data, tbl[i].e_od);
        chk("tbl_out_idx", out_idx, tbl[i].e_idx);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush    = 1'b0;

    // Back-to-back random groups with the sink always ready.
    for (int i = 0; i < 64; i++) src[i] = $urandom;
    wi = 0; beats = 0; first = -1; lastc = -1; drops = 0;
    for (int c = 0; c < 300 && beats < 64; c++) begin
      in_valid = (wi < 64);
      in_data  = (wi < 64) ? src[wi] : 32'h0;
      @(negedge clk);
      if (wi < 64 && !in_ready) drops++;
      if (out_valid) begin
        chk("b2b_data", out_data, tp((beats / 16) * 16, 16, beats % 16));
        chk("b2b_idx", out_idx, beats % 16);
        if (first < 0) first = c;
        lastc = c;
        beats++;
      end
      if (in_valid && in_ready) wi++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_in_ready_drops", drops, 0);
    chk("b2b_beats", beats, 64);
    chk("b2b_contiguous", lastc - first + 1, 64);

    // Backpressure: both banks fill, the 33rd word stalls until group 0 drains.
    for (int i = 0; i < 64; i++) src[i] = $urandom;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) push_word(src[i], 1'b0);
    in_valid = 1'b1;
    in_data  = src[32];
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_idx", out_idx, 0);
      chk("bp_hold_data", out_data, tp(0, 16, 0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      chk("bp_g0_idx", out_idx, s);
      chk("bp_g0_data", out_data, tp(0, 16, s));
      chk("bp_g0_last", out_last, (s == 15));
      chk("bp_g0_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      if (s == 0) chk("bp_resume_in_ready", in_ready, 1);
      chk("bp_g1_idx", out_idx, s);
      chk("bp_g1_data", out_data, tp(16, 16, s));
      @(posedge clk); #1;
      if (s == 0) in_valid = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("bp_flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    drain(32, 1, "bp_g2");
    @(negedge clk);
    chk("bp_idle_valid", out_valid, 0);
    @(posedge clk); #1;

    // Flush together with the last lane closes exactly one full group.
    for (int i = 0; i < 15; i++) push_word(src[i], 1'b0);
    push_word(src[15], 1'b1);
    drain(0, 16, "fl_last");
    @(negedge clk);
    chk("fl_last_single", out_valid, 0);
    @(posedge clk); #1;

    // Reset in the middle of a drain, then a fresh group.
    for (int i = 0; i < 16; i++) push_word(src[i], 1'b0);
    t = 0;
    @(negedge clk);
    while (!(out_valid && out_idx == 4'd7) && t < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      t++;
    end
    chk("mid_reach_beat7", out_idx, 7);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_data", out_data, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", in_ready, 1);
    chk("mid_rel_valid", out_valid, 0);
    @(posedge clk); #1;
    for (int i = 16; i < 32; i++) push_word(src[i], 1'b0);
    drain(16, 16, "mid_fresh");
    @(negedge clk);
    chk("mid_end_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
